// File: rtl/apb_uart_pkg.sv
// apb_uart_pkg: register map, poller states and data-size mask for the apb_uart_rx poller
package apb_uart_pkg;
  localparam logic [2:0] ADDR_DATA_SR  = 3'd0;
  localparam logic [2:0] ADDR_ERROR_SR = 3'd1;
  localparam logic [2:0] ADDR_BIT_CR0  = 3'd2;
  localparam logic [2:0] ADDR_BIT_CR1  = 3'd3;
  localparam logic [2:0] ADDR_DATA_CR  = 3'd4;
  localparam logic [2:0] ADDR_RX_DATA  = 3'd6;
  typedef enum logic [3:0] {
    IDLE, WR_CR0, WR_CR1, WR_DCR, POLL, RD_ERR, RD_DATA, DELIVER, GAP
  } poller_state_t;
  // out-of-range sizes (0, >8) behave as a full 8-bit frame
  function automatic logic [7:0] data_mask(input logic [3:0] size);
    logic [3:0] n;
    n = (size == 4'd0 || size > 4'd8) ? 4'd8 : size;
    return 8'hFF >> (4'd8 - n);
  endfunction
endpackage

// File: rtl/apb_master_xfer.sv
// apb_master_xfer: single two-cycle APB transfer engine with registered done/rdata/err
module apb_master_xfer (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic       write,
  input  logic [2:0] addr,
  input  logic [7:0] wdata,
  output logic       psel,
  output logic [2:0] paddr,
  output logic       penable,
  output logic       pwrite,
  output logic [7:0] pwdata,
  input  logic [7:0] prdata,
  input  logic       pslverr,
  output logic       done,
  output logic [7:0] rdata,
  output logic       err
);
  // done lands one cycle after ACCESS, which also provides the idle cycle between transfers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= 3'd0;
      pwdata  <= 8'h00;
      done    <= 1'b0;
      err     <= 1'b0;
      rdata   <= 8'h00;
    end else begin
      done <= psel && penable;
      err  <= psel && penable && pslverr;
      if (psel && penable) rdata <= prdata;
      if (start && !psel) begin
        psel    <= 1'b1;
        penable <= 1'b0;
        pwrite  <= write;
        paddr   <= addr;
        pwdata  <= wdata;
      end else if (psel && !penable) begin
        penable <= 1'b1;
      end else if (psel && penable) begin
        psel    <= 1'b0;
        penable <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/apb_uart_rx_poller.sv
// apb_uart_rx_poller: configures apb_uart_rx over APB, polls it and streams received bytes
module apb_uart_rx_poller
  import apb_uart_pkg::*;
#(
  parameter int POLL_GAP = 4
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        run,
  input  logic        cfg_start,
  input  logic [13:0] cfg_bit_period,
  input  logic [3:0]  cfg_data_size,
  input  logic        err_clear,
  output logic        psel,
  output logic [2:0]  paddr,
  output logic        penable,
  output logic        pwrite,
  output logic [7:0]  pwdata,
  input  logic [7:0]  prdata,
  input  logic        pslverr,
  output logic        rx_valid,
  output logic [7:0]  rx_byte,
  input  logic        rx_ready,
  output logic [1:0]  err_flags,
  output logic        bus_fault,
  output logic        busy
);
  poller_state_t state, next_state;
  logic [5:0] period_hi;
  logic [3:0] size_q;
  logic [7:0] gap_cnt;
  logic       xfer_start, xfer_write, xfer_done, xfer_err;
  logic [2:0] xfer_addr;
  logic [7:0] xfer_wdata, xfer_rdata;
  logic       hs;
  assign hs   = rx_valid && rx_ready;
  assign busy = state != IDLE;
  apb_master_xfer u_xfer (
    .clk(clk), .n_rst(n_rst), .start(xfer_start), .write(xfer_write),
    .addr(xfer_addr), .wdata(xfer_wdata), .psel(psel), .paddr(paddr),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata),
    .pslverr(pslverr), .done(xfer_done), .rdata(xfer_rdata), .err(xfer_err)
  );
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else state <= next_state;
  end
  always_comb begin
    next_state = state;
    if (xfer_done && xfer_err) next_state = IDLE;
    else begin
      case (state)
        IDLE:    if (cfg_start) next_state = WR_CR0;
        WR_CR0:  if (xfer_done) next_state = WR_CR1;
        WR_CR1:  if (xfer_done) next_state = WR_DCR;
        WR_DCR:  if (xfer_done) next_state = run ? POLL : IDLE;
        POLL:    if (xfer_done) next_state = !run ? IDLE : xfer_rdata[0] ? RD_ERR : GAP;
        RD_ERR:  if (xfer_done) next_state = run ? RD_DATA : IDLE;
        RD_DATA: if (xfer_done) next_state = DELIVER;
        DELIVER: if (hs) next_state = run ? POLL : IDLE;
        GAP:     next_state = !run ? IDLE : (gap_cnt == 8'(POLL_GAP - 1)) ? POLL : GAP;
        default: next_state = IDLE;
      endcase
    end
  end
  // a transfer is requested on the edge that enters a bus state, so SETUP follows immediately
  always_comb begin
    xfer_start = (next_state != state) &&
                 (next_state inside {WR_CR0, WR_CR1, WR_DCR, POLL, RD_ERR, RD_DATA});
    xfer_write = next_state inside {WR_CR0, WR_CR1, WR_DCR};
    xfer_addr  = next_state == WR_CR0  ? ADDR_BIT_CR0  :
                 next_state == WR_CR1  ? ADDR_BIT_CR1  :
                 next_state == WR_DCR  ? ADDR_DATA_CR  :
                 next_state == RD_ERR  ? ADDR_ERROR_SR :
                 next_state == RD_DATA ? ADDR_RX_DATA  : ADDR_DATA_SR;
    xfer_wdata = next_state == WR_CR0 ? cfg_bit_period[7:0] :
                 next_state == WR_CR1 ? {2'b00, period_hi} :
                 next_state == WR_DCR ? {4'b0000, size_q} : 8'h00;
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      period_hi <= 6'd0;
      size_q    <= 4'd0;
      gap_cnt   <= 8'd0;
      rx_valid  <= 1'b0;
      rx_byte   <= 8'h00;
      err_flags <= 2'b00;
      bus_fault <= 1'b0;
    end else begin
      if (state == IDLE && cfg_start) begin
        period_hi <= cfg_bit_period[13:8];
        size_q    <= cfg_data_size;
      end
      gap_cnt <= (state == GAP) ? gap_cnt + 8'd1 : 8'd0;
      if (state == RD_DATA && xfer_done && !xfer_err) begin
        rx_byte  <= xfer_rdata & data_mask(size_q);
        rx_valid <= 1'b1;
      end else if (hs) begin
        rx_valid <= 1'b0;
      end
      err_flags <= (err_clear ? 2'b00 : err_flags) |
                   ((state == RD_ERR && xfer_done && !xfer_err) ? xfer_rdata[1:0] : 2'b00);
      bus_fault <= (bus_fault && !err_clear) || (xfer_done && xfer_err);
    end
  end
endmodule

// File: tb/tb_apb_uart_rx_poller.sv
// tb_apb_uart_rx_poller: directed bench with a behavioural apb_uart_rx slave and transfer log
module tb_apb_uart_rx_poller;
  logic        tb_clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        run = 1'b0;
  logic        cfg_start = 1'b0;
  logic [13:0] cfg_bit_period = 14'd0;
  logic [3:0]  cfg_data_size = 4'd0;
  logic        err_clear = 1'b0;
  logic        rx_ready = 1'b0;
  logic        psel, penable, pwrite, pslverr, rx_valid, bus_fault, busy;
  logic [2:0]  paddr;
  logic [7:0]  pwdata, prdata, rx_byte;
  logic [1:0]  err_flags;
  int          tests = 0;
  int          failed = 0;
  int          cyc = 0;
  int          frames_sent = 0;
  int          reads6 = 0;
  int          proto_err = 0;
  logic [7:0]  fdata = 8'h00;
  logic [1:0]  ferr = 2'b00;
  logic        force_err = 1'b0;
  logic [2:0]  fault_addr = 3'd0;
  logic        prev_setup = 1'b0;
  logic        prev_access = 1'b0;
  logic [2:0]  prev_addr = 3'd0;
  logic        log_w[$];
  logic [2:0]  log_a[$];
  logic [7:0]  log_d[$];
  int          log_t[$];

  always #5 tb_clk = ~tb_clk;

  // slave: status bit0 stays set until the data register has been read for every sent frame
  assign prdata  = paddr == 3'd0 ? {7'b0, frames_sent > reads6} :
                   paddr == 3'd1 ? {6'b0, ferr} :
                   paddr == 3'd6 ? fdata : 8'h00;
  assign pslverr = psel && penable && force_err && paddr == fault_addr;

  apb_uart_rx_poller #(.POLL_GAP(4)) dut (
    .clk(tb_clk), .n_rst(n_rst), .run(run), .cfg_start(cfg_start),
    .cfg_bit_period(cfg_bit_period), .cfg_data_size(cfg_data_size),
    .err_clear(err_clear), .psel(psel), .paddr(paddr), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pslverr(pslverr),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_ready(rx_ready),
    .err_flags(err_flags), .bus_fault(bus_fault), .busy(busy)
  );

  always @(posedge tb_clk) begin
    cyc <= cyc + 1;
    if (psel && penable) begin
      log_w.push_back(pwrite);
      log_a.push_back(paddr);
      log_d.push_back(pwrite ? pwdata : prdata);
      log_t.push_back(cyc);
      if (!pwrite && paddr == 3'd6) reads6 <= reads6 + 1;
      if (!prev_setup || paddr != prev_addr) proto_err <= proto_err + 1;
    end
    if (psel && !penable && prev_access) proto_err <= proto_err + 1;
    prev_setup  <= psel && !penable;
    prev_access <= psel && penable;
    prev_addr   <= paddr;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge tb_clk);
  endtask

  task automatic check_wr(input int i, input logic [2:0] a, input logic [7:0] d);
    check($sformatf("cfg_wr%0d", i), {log_w[i], log_a[i], log_d[i]}, {1'b1, a, d});
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!rx_valid && n < 100) begin
      tick(1);
      n++;
    end
    check(tag, rx_valid, 1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] e);
    fdata = d;
    ferr = e;
    frames_sent++;
  endtask

  initial begin
    int m;
    int n;
    logic stable;
    tick(2);
    check("rst_psel", psel, 0);
    check("rst_apb", {penable, pwrite, paddr, pwdata}, 0);
    check("rst_rx", {rx_valid, rx_byte}, 0);
    check("rst_err", {err_flags, bus_fault}, 0);
    check("rst_busy", busy, 0);
    n_rst = 1'b1;
    tick(1);
    // configuration writes then idle polling
    run = 1'b1;
    cfg_bit_period = 14'd10;
    cfg_data_size = 4'd8;
    cfg_start = 1'b1;
    tick(1);
    cfg_start = 1'b0;
    check("cfg_setup", {psel, penable, paddr, busy}, {1'b1, 1'b0, 3'd2, 1'b1});
    tick(30);
    check_wr(0, 3'd2, 8'h0A);
    check_wr(1, 3'd3, 8'h00);
    check_wr(2, 3'd4, 8'h08);
    check("wr_spacing", {log_t[1] - log_t[0], log_t[2] - log_t[1]}, {32'd3, 32'd3});
    check("first_poll", {log_w[3], log_a[3]}, {1'b0, 3'd0});
    check("poll_period", {log_t[4] - log_t[3], log_t[5] - log_t[4]}, {32'd7, 32'd7});
    check("idle_poll", {rx_valid, busy}, 2'b01);
    // byte at size 8 with consumer ready
    rx_ready = 1'b1;
    send_frame(8'hA5, 2'b00);
    wait_valid("f1_valid");
    n = log_a.size();
    check("f1_byte", rx_byte, 8'hA5);
    check("f1_seq", {log_a[n-3], log_a[n-2], log_a[n-1]}, {3'd0, 3'd1, 3'd6});
    check("f1_status", log_d[n-3], 8'h01);
    tick(1);
    check("f1_pulse", rx_valid, 0);
    check("f1_err", err_flags, 2'b00);
    // reconfigure to 5-bit frames
    run = 1'b0;
    tick(10);
    check("stop_idle", busy, 0);
    run = 1'b1;
    cfg_bit_period = 14'h1234;
    cfg_data_size = 4'd5;
    m = log_a.size();
    cfg_start = 1'b1;
    tick(1);
    cfg_start = 1'b0;
    tick(12);
    check_wr(m, 3'd2, 8'h34);
    check_wr(m + 1, 3'd3, 8'h12);
    check_wr(m + 2, 3'd4, 8'h05);
    // backpressure holds the byte and stops polling
    rx_ready = 1'b0;
    send_frame(8'hF5, 2'b00);
    wait_valid("bp_valid");
    m = log_a.size();
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (!rx_valid || rx_byte !== 8'h15 || psel) stable = 1'b0;
    end
    check("bp_hold", stable, 1);
    check("bp_byte", rx_byte, 8'h15);
    check("bp_noapb", log_a.size(), m);
    rx_ready = 1'b1;
    tick(1);
    check("bp_release", {rx_valid, psel}, 2'b01);
    // framing error is sticky until err_clear
    send_frame(8'h0A, 2'b01);
    wait_valid("fe_valid");
    check("fe_byte", rx_byte, 8'h0A);
    tick(1);
    check("fe_flag", err_flags, 2'b01);
    send_frame(8'h0B, 2'b00);
    wait_valid("fe2_valid");
    check("fe2_byte", rx_byte, 8'h0B);
    check("fe_sticky", err_flags, 2'b01);
    tick(1);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    check("fe_clear", err_flags, 2'b00);
    send_frame(8'hFF, 2'b10);
    wait_valid("ov_valid");
    check("ov_mask", rx_byte, 8'h1F);
    tick(1);
    check("ov_flag", err_flags, 2'b10);
    // run=0 while waiting between polls
    n = 0;
    while (!(psel && penable) && n < 50) begin
      tick(1);
      n++;
    end
    check("gap_find", psel && penable, 1);
    tick(2);
    check("gap_in", {busy, psel}, 2'b10);
    run = 1'b0;
    tick(1);
    check("gap_exit", {busy, psel}, 2'b00);
    // asynchronous reset in the middle of a transfer
    run = 1'b1;
    cfg_bit_period = 14'd10;
    cfg_data_size = 4'd8;
    cfg_start = 1'b1;
    tick(1);
    cfg_start = 1'b0;
    n_rst = 1'b0;
    #1;
    check("rst_mid", {psel, penable, busy, err_flags}, 0);
    tick(1);
    n_rst = 1'b1;
    tick(1);
    // slave error on the second configuration write
    force_err = 1'b1;
    fault_addr = 3'd3;
    m = log_a.size();
    cfg_start = 1'b1;
    tick(1);
    cfg_start = 1'b0;
    tick(15);
    check("fault_flag", bus_fault, 1);
    check("fault_idle", busy, 0);
    check("fault_count", log_a.size(), m + 2);
    check("fault_last", log_a[m+1], 3'd3);
    force_err = 1'b0;
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    check("fault_clear", bus_fault, 0);
    check("protocol", proto_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/apb_uart_rx_poller.md
Name: apb_uart_rx_poller

Overview:
- APB master controller that configures and services the apb_uart_rx slave.
- On a start pulse it writes bit period and data size to the slave. It then polls the data status register and fetches each received byte plus the error flags.
- Delivers each byte on a valid/ready stream to downstream logic.
- Sits between apb_uart_rx and the consumer. It is the only APB master on that slave.

Parameters:
POLL_GAP, 4, idle cycles between an empty status poll and the next poll (1..255)

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
run  input  1  level; 1 = service loop enabled
cfg_start  input  1  one-cycle pulse; latch cfg_* and begin configuration
cfg_bit_period  input  14  bit period in clocks
cfg_data_size  input  4  data bits per frame (5..8)
err_clear  input  1  one-cycle pulse; clears err_flags and bus_fault
psel  output  1  APB select
paddr  output  3  APB address
penable  output  1  APB enable
pwrite  output  1  APB write
pwdata  output  8  APB write data
prdata  input  8  APB read data
pslverr  input  1  APB slave error
rx_valid  output  1  byte available
rx_byte  output  8  received byte, bits at and above data_size forced to 0
rx_ready  input  1  consumer accepts byte
err_flags  output  2  sticky {overrun, framing}, from error status bit1/bit0
bus_fault  output  1  sticky; pslverr seen
busy  output  1  1 whenever state != IDLE

Behaviour:
- Reset (async, n_rst=0): state=IDLE. All APB outputs 0. rx_valid=0, rx_byte=0, err_flags=0, bus_fault=0, latched config=0, gap counter=0.
- All outputs are registered.
- Every APB transfer is exactly 2 cycles: SETUP (psel=1, penable=0) then ACCESS (psel=1, penable=1). No wait states.
- paddr, pwrite and pwdata are stable across both cycles. prdata and pslverr are sampled on the clock edge ending ACCESS.
- psel=0 between transfers for at least 1 cycle.
- States:
  - IDLE
  - WR_CR0 (addr 2, period[7:0])
  - WR_CR1 (addr 3, {2'b00, period[13:8]})
  - WR_DCR (addr 4, {4'b0, data_size})
  - POLL (read addr 0)
  - RD_ERR (read addr 1)
  - RD_DATA (read addr 6)
  - DELIVER
  - GAP
- IDLE -> WR_CR0 when cfg_start=1; cfg_* are latched on that edge. SETUP of WR_CR0 appears on the next cycle.
- cfg_start is ignored outside IDLE.
- WR_CR0 -> WR_CR1 -> WR_DCR -> POLL, one transfer each.
- POLL:
  - prdata[0]=1 -> RD_ERR.
  - prdata[0]=0 -> GAP.
- GAP counts POLL_GAP cycles, then -> POLL.
- RD_ERR: err_flags |= prdata[1:0], then -> RD_DATA.
- RD_DATA: rx_byte = prdata & mask(data_size); rx_valid=1 from the next cycle; -> DELIVER.
  - mask(8)=8'hFF, mask(5)=8'h1F.
  - data_size >8 or 0 is treated as 8.
- DELIVER:
  - Hold rx_valid and rx_byte stable until rx_valid && rx_ready on a clock edge.
  - On that edge: rx_valid=0, -> POLL, or -> IDLE if run=0.
  - No further polling while rx_valid=1 (backpressure is absorbed by the slave's overrun logic).
- run=0:
  - Sampled only at transfer boundaries and in GAP.
  - An in-progress transfer always completes.
  - In GAP or after a read completes, go to IDLE.
  - The configuration writes always complete regardless of run.
  - After WR_DCR, if run=0 -> IDLE.
- pslverr=1 at the end of any ACCESS: bus_fault=1, abort the sequence, -> IDLE. No retry.
- err_clear: clears err_flags and bus_fault on the next edge. If RD_ERR sets a bit on the same edge, set wins.
- Reset mid-transfer: the bus returns to idle immediately (psel=0); no partial state is retained.
- Config re-apply requires returning to IDLE (run=0), then a new cfg_start.

Decomposition:
- Package apb_uart_pkg:
  - Address localparams ADDR_DATA_SR=0, ADDR_ERROR_SR=1, ADDR_BIT_CR0=2, ADDR_BIT_CR1=3, ADDR_DATA_CR=4, ADDR_RX_DATA=6.
  - State enum poller_state_t.
- One sub-module, apb_master_xfer:
  - Takes start, write, addr, wdata.
  - Drives the two-phase APB handshake.
  - Returns done, rdata and err pulses.
- The top FSM sequences requests to apb_master_xfer.

Test Plan:
1. Reset then cfg_start with period=10, size=8, run=1 -> exactly 3 writes: (2, 8'h0A), (3, 8'h00), (4, 8'h08), each 2 cycles with psel gaps; then reads of addr 0 begin.
2. Slave idle, POLL_GAP=4 -> addr 0 read repeats every 2+1+4 cycles; rx_valid stays 0; busy=1.
3. Send UART frame 8'hA5 at size 8 with rx_ready=1 -> reads addr 0, 1, 6 in order; rx_byte=8'hA5 with a 1-cycle rx_valid pulse; err_flags=0.
4. Size 5, frame 5'b10101, rx_ready=0 for 20 cycles -> rx_byte=8'h15 held stable with rx_valid=1; no APB activity until rx_ready=1.
5. Framing error (stop bit 0) -> err_flags=2'b01 sticky across later clean bytes; err_clear returns it to 0.
6. Force pslverr on WR_CR1 -> bus_fault=1, state IDLE, no WR_DCR issued; run=0 mid-GAP -> IDLE within 1 cycle, busy=0.
